// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch
// and data access, alternating grants when both sides contend.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byte_en,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP
    } state_t;

    state_t state;
    logic   last_d;
    logic   i_req;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // On contention the side that did not win last time gets the port.
    assign grant_d = d_req && (!i_req || !last_d);
    assign grant_i = i_req && (!d_req || last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_d      <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_byte_en <= 4'h0;
            i_rdata     <= 32'h0;
            d_rdata     <= 32'h0;
            i_resp      <= 1'b0;
            d_resp      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= SERVE_D;
                        last_d      <= 1'b1;
                        mem_read    <= !d_write;
                        mem_write   <= d_write;
                        mem_address <= d_address;
                        mem_wdata   <= d_wdata;
                        mem_byte_en <= d_write ? d_byte_en : 4'hF;
                    end else if (grant_i) begin
                        state       <= SERVE_I;
                        last_d      <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_address <= i_address;
                        mem_wdata   <= 32'h0;
                        mem_byte_en <= 4'hF;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state       <= RESP;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_address <= 32'h0;
                        mem_wdata   <= 32'h0;
                        mem_byte_en <= 4'h0;
                        if (state == SERVE_D) begin
                            d_rdata <= mem_rdata;
                            d_resp  <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_resp  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued when
// requests are driven and popped when the arbiter pulses a resp.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_address = 32'h0;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_byte_en = 4'h0;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_resp = 1'b0;

    typedef struct {
        bit          side_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    bit   auto_mem = 1'b0;
    int   auto_cnt = 0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    // Simple memory: answers on the second serving cycle with addr ^ KEY.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (mem_read || mem_write) begin
                if (auto_cnt == 1) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_address ^ KEY;
                    auto_cnt  = 0;
                end else begin
                    auto_cnt++;
                end
            end else begin
                auto_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        i_read = 1'b1;
        i_address = 32'h44;
        #2;
        checks++;
        if (mem_read !== 1'b0 || mem_address !== 32'h0)
            $display("FAIL reset_async mem_read=%b addr=%h want 0",
                     mem_read, mem_address);
        else passed++;
        tick();
        tick();
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_byte_en !== 4'h0)
            $display("FAIL reset_mem rd=%b wr=%b be=%h want 0",
                     mem_read, mem_write, mem_byte_en);
        else passed++;
        checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0 ||
            i_rdata !== 32'h0 || d_rdata !== 32'h0)
            $display("FAIL reset_resp ir=%b dr=%b id=%h dd=%h want 0",
                     i_resp, d_resp, i_rdata, d_rdata);
        else passed++;
        i_read = 1'b0;
        i_address = 32'h0;
    endtask

    task automatic test_back_to_back();
        int  got;
        bit  prev_resp;
        rst = 1'b1;
        i_read = 1'b1;
        i_address = 32'h100;
        d_read = 1'b1;
        d_address = 32'h200;
        sb.push_back('{1'b1, 32'hA5A5_0200});
        sb.push_back('{1'b0, 32'hA5A5_0100});
        sb.push_back('{1'b1, 32'hA5A5_0200});
        sb.push_back('{1'b0, 32'hA5A5_0100});
        auto_mem = 1'b1;
        tick();
        rst = 1'b0;
        got = 0;
        prev_resp = 1'b0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            tick();
            checks++;
            if (i_resp && d_resp)
                $display("FAIL b2b_both_resp at cycle %0d", c);
            else passed++;
            if (i_resp || d_resp) begin
                exp_t e;
                checks++;
                if (prev_resp)
                    $display("FAIL b2b_resp_width resp high 2 cycles at %0d", c);
                else passed++;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL b2b_extra_resp i=%b d=%b want none",
                             i_resp, d_resp);
                end else begin
                    e = sb.pop_front();
                    got++;
                    checks++;
                    if (d_resp !== e.side_d)
                        $display("FAIL b2b_order#%0d d_side=%b want %b",
                                 got, d_resp, e.side_d);
                    else passed++;
                    checks++;
                    if ((d_resp ? d_rdata : i_rdata) !== e.data)
                        $display("FAIL b2b_data#%0d got=%h want %h", got,
                                 d_resp ? d_rdata : i_rdata, e.data);
                    else passed++;
                end
                if (got == 4) begin
                    i_read = 1'b0;
                    d_read = 1'b0;
                end
            end
            prev_resp = i_resp | d_resp;
        end
        checks++;
        if (sb.size() != 0)
            $display("FAIL b2b_timeout pending=%0d want 0", sb.size());
        else passed++;
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
        tick();
        auto_mem = 1'b0;
        sb.delete();
    endtask

    task automatic test_i_read();
        exp_t e;
        i_read = 1'b1;
        i_address = 32'h60;
        sb.push_back('{1'b0, 32'h0000_0013});
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h60 ||
            mem_byte_en !== 4'hF || mem_write !== 1'b0)
            $display("FAIL iread_strobe rd=%b wr=%b a=%h be=%h want 1 0 60 f",
                     mem_read, mem_write, mem_address, mem_byte_en);
        else passed++;
        tick();
        mem_rdata = 32'h0000_0013;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        i_read = 1'b0;
        e = sb.pop_front();
        checks++;
        if (i_resp !== 1'b1 || i_rdata !== e.data)
            $display("FAIL iread_resp resp=%b data=%h want 1 %h",
                     i_resp, i_rdata, e.data);
        else passed++;
        checks++;
        if (d_resp !== 1'b0 || mem_read !== 1'b0)
            $display("FAIL iread_side d_resp=%b mem_read=%b want 0 0",
                     d_resp, mem_read);
        else passed++;
        tick();
        checks++;
        if (i_resp !== 1'b0 || i_rdata !== 32'h13)
            $display("FAIL iread_hold resp=%b data=%h want 0 13",
                     i_resp, i_rdata);
        else passed++;
    endtask

    task automatic test_d_write();
        exp_t e;
        d_write = 1'b1;
        d_address = 32'h1004;
        d_wdata = 32'hDEAD_BEEF;
        d_byte_en = 4'b0011;
        sb.push_back('{1'b1, 32'h0BAD_F00D});
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
            mem_address !== 32'h1004 || mem_wdata !== 32'hDEAD_BEEF ||
            mem_byte_en !== 4'b0011)
            $display("FAIL dwrite_fields wr=%b rd=%b a=%h wd=%h be=%h",
                     mem_write, mem_read, mem_address, mem_wdata, mem_byte_en);
        else passed++;
        d_address = 32'hFFFF_0000;
        d_wdata = 32'h1234_5678;
        d_byte_en = 4'hF;
        d_write = 1'b0;
        d_read = 1'b1;
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h1004 ||
            mem_wdata !== 32'hDEAD_BEEF || mem_byte_en !== 4'b0011)
            $display("FAIL dwrite_latched wr=%b a=%h wd=%h be=%h",
                     mem_write, mem_address, mem_wdata, mem_byte_en);
        else passed++;
        d_read = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        e = sb.pop_front();
        checks++;
        if (d_resp !== 1'b1 || d_rdata !== e.data || i_resp !== 1'b0)
            $display("FAIL dwrite_resp dr=%b dd=%h ir=%b want 1 %h 0",
                     d_resp, d_rdata, i_resp, e.data);
        else passed++;
        checks++;
        if (i_rdata !== 32'h13)
            $display("FAIL dwrite_other_rdata i_rdata=%h want 13", i_rdata);
        else passed++;
        tick();
        checks++;
        if (d_resp !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL dwrite_after dr=%b wr=%b want 0 0",
                     d_resp, mem_write);
        else passed++;
    endtask

    task automatic test_stray_resp_and_rw();
        exp_t e;
        mem_rdata = 32'h1234_5678;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0 ||
            i_rdata !== 32'h13 || d_rdata !== 32'h0BAD_F00D ||
            mem_read !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL stray_resp ir=%b dr=%b id=%h dd=%h rd=%b wr=%b",
                     i_resp, d_resp, i_rdata, d_rdata, mem_read, mem_write);
        else passed++;
        d_read = 1'b1;
        d_write = 1'b1;
        d_address = 32'h88;
        d_wdata = 32'h55AA_55AA;
        d_byte_en = 4'b1100;
        sb.push_back('{1'b1, 32'h0000_0077});
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
            mem_byte_en !== 4'b1100 || mem_wdata !== 32'h55AA_55AA)
            $display("FAIL rw_as_write wr=%b rd=%b be=%h wd=%h",
                     mem_write, mem_read, mem_byte_en, mem_wdata);
        else passed++;
        mem_rdata = 32'h77;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        e = sb.pop_front();
        checks++;
        if (d_resp !== 1'b1 || d_rdata !== e.data)
            $display("FAIL rw_resp dr=%b dd=%h want 1 %h",
                     d_resp, d_rdata, e.data);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_serve();
        d_read = 1'b1;
        d_address = 32'h40;
        tick();
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h40)
            $display("FAIL mid_serve rd=%b a=%h want 1 40",
                     mem_read, mem_address);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_address !== 32'h0 ||
            mem_byte_en !== 4'h0 || d_rdata !== 32'h0 || i_rdata !== 32'h0)
            $display("FAIL reset_mid rd=%b a=%h be=%h dd=%h id=%h want 0",
                     mem_read, mem_address, mem_byte_en, d_rdata, i_rdata);
        else passed++;
        d_read = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (d_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0)
                $display("FAIL post_reset c%0d dr=%b rd=%b wr=%b want 0",
                         c, d_resp, mem_read, mem_write);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_i_read();
        test_d_write();
        test_stray_resp_and_rw();
        test_reset_mid_serve();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have no parameters; all address and data widths are fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_read  input  1  instruction-side read request; held high until i_resp.
REQ-005 i_address  input  32  instruction fetch address.
REQ-006 i_rdata  output  32  instruction read data; valid when i_resp=1.
REQ-007 i_resp  output  1  instruction request complete, one-cycle pulse.
REQ-008 d_read  input  1  data-side read request; held until d_resp.
REQ-009 d_write  input  1  data-side write request; held until d_resp.
REQ-010 d_address  input  32  data access address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_byte_en  input  4  store byte enables.
REQ-013 d_rdata  output  32  load data; valid when d_resp=1.
REQ-014 d_resp  output  1  data request complete, one-cycle pulse.
REQ-015 mem_read, mem_write  output  1 each  shared memory port strobes.
REQ-016 mem_address, mem_wdata  output  32 each  shared port address and store data.
REQ-017 mem_byte_en  output  4  shared port byte enables.
REQ-018 mem_rdata  input  32; mem_resp  input  1  memory completion, data valid same cycle.

Function
REQ-019 States SHALL be IDLE, SERVE_I, SERVE_D, RESP.
REQ-020 IDLE: a D request with no I request, or with last_grant=I, -> SERVE_D; an I request with no D request, or with last_grant=D, -> SERVE_I; otherwise stay.
REQ-021 On each grant, the winner's address, wdata, byte_en and read/write kind SHALL be latched, and last_grant SHALL be set to the winner.
REQ-022 In SERVE_I/SERVE_D, mem_* SHALL be driven only from the latched request, so changes on requester inputs have no effect; mem_byte_en=4'hF for reads.
REQ-023 Outside SERVE states, mem_read=mem_write=0 and mem_address, mem_wdata, mem_byte_en=0.
REQ-024 mem_resp in a SERVE state SHALL capture mem_rdata into the winner's rdata register and transition to RESP.
REQ-025 RESP lasts exactly one cycle: the winner's resp=1, its rdata holds the captured value, no grant is made, then -> IDLE.
REQ-026 i_rdata/d_rdata SHALL hold their last captured value until the next completion for that side; the other side's rdata is unchanged.
REQ-027 Latency: request first seen high in IDLE at cycle N -> mem strobe at N+1; mem_resp at cycle M -> resp at M+1; earliest next grant evaluated at M+2.
REQ-028 d_read and d_write both high SHALL be treated as a write; the read is ignored.
REQ-029 mem_resp while in IDLE or RESP SHALL be ignored with no state or output change.
REQ-030 A requester dropping its request mid-SERVE SHALL NOT abort the transfer; the response is still pulsed.
REQ-031 i_resp and d_resp SHALL never both be 1 in the same cycle.

Reset
REQ-032 While rst=1, state=IDLE, last_grant=I, and all outputs (mem_*, i_rdata, d_rdata, i_resp, d_resp) SHALL be 0, independent of clk.
REQ-033 Reset during SERVE_x SHALL drop the transfer; no resp is issued for it after reset releases.

Verification
REQ-034 i_read=1, i_address=0x60 only; mem_resp with rdata=0x00000013 three cycles later -> mem_read=1 with addr 0x60 from N+1; i_resp=1 and i_rdata=0x13 one cycle after mem_resp; d_resp stays 0.
REQ-035 d_write=1, addr=0x1004, wdata=0xDEADBEEF, byte_en=4'b0011 -> mem_write=1 with identical fields; after mem_resp, d_resp pulses once; inputs changed mid-SERVE leave mem_* unchanged.
REQ-036 i_read and d_read held high together from reset -> order of grants D, I, D, I; each resp is exactly one cycle.
REQ-037 rst asserted two cycles into SERVE_D, between clock edges -> all outputs 0 immediately; after release with requests low, no d_resp appears and mem strobes stay 0.
REQ-038 mem_resp pulsed in IDLE, and d_read=d_write=1 -> no output change for the stray mem_resp; a write is issued with mem_read=0.
